dpram_fifo_ctrl: RTL and testbench
==================================

// Module: dpram_fifo_ctrl
// PURPOSE
//  First-word-fall-through FIFO controller that sequences one internal dpram instance.
//  - Owns the dpram write/read pointers, write enable and occupancy.
//  - Exposes valid/ready handshakes on both sides.
//  - Used in the hybrid cache as the refill/writeback buffer between the cache core and the memory bus.
// PARAMETERS
//  DATABITS  8  width of one FIFO entry (passed to dpram)
//  ADDRBITS  5  dpram address width; depth DEPTH = 2**ADDRBITS
//  AFULL     (2**ADDRBITS)-2  level at or above which almost_full is asserted
// PORTS
//  clk          in   1            clock, all state on rising edge
//  reset        in   1            asynchronous, active-high reset
//  flush        in   1            synchronous clear of FIFO state
//  in_valid     in   1            write side: entry offered
//  in_ready     out  1            write side: FIFO can accept
//  in_data      in   DATABITS     write side: entry
//  out_valid    out  1            read side: entry available
//  out_ready    in   1            read side: consumer takes entry
//  out_data     out  DATABITS     read side: head entry (dpram q)
//  level        out  ADDRBITS+1   current occupancy, 0..DEPTH
//  almost_full  out  1            level >= AFULL
//  high_water   out  ADDRBITS+1   maximum level since reset/flush
// BEHAVIOUR
//  Reset (asynchronous)
//  - wrptr, rdptr, level and high_water go to 0.
//  - Therefore in_ready=1, out_valid=0, almost_full=0 (AFULL>0).
//  - dpram contents are not reset.
//  Handshake signals
//  - push = in_valid & in_ready. pop = out_valid & out_ready.
//  - in_ready = (level != DEPTH). It is registered-state only; there is no combinational path from out_ready.
//  - out_valid = (level != 0).
//  dpram connection
//  - wraddr = wrptr[ADDRBITS-1:0], we = push, in = in_data.
//  - rdaddr = rdptr[ADDRBITS-1:0], out_data = q (combinational read).
//  Pointers
//  - Both pointers are ADDRBITS wide and increment by 1 on push/pop.
//  - Natural wrap DEPTH-1 -> 0.
//  Latency
//  - An entry pushed at edge N is visible on out_data, with out_valid=1, after edge N (1 cycle).
//  - No fall-through within the same cycle: push into an empty FIFO does not make out_valid high in that cycle.
//  Level update per edge
//  - push & !pop: +1. pop & !push: -1. Both or neither: unchanged.
//  Simultaneous cases
//  - Full: pop allowed. push blocked by in_ready=0 even if pop occurs (in_ready is not combinationally re-opened).
//  - Empty: pop impossible (out_valid=0). A push is accepted normally.
//  - Push+pop at level 1: the old head leaves, the new entry becomes head next cycle, level stays 1.
//  high_water
//  - Updated to the next level whenever the next level > high_water.
//  - Saturates naturally at DEPTH.
//  flush
//  - Takes priority over push/pop in the same cycle.
//  - Next state: wrptr=rdptr=0, level=0, high_water=0.
//  - A push coincident with flush is discarded. we is forced 0 during flush.
//  Other
//  - Consumer holding out_ready=0: head entry and out_data stay stable.
//  - Producer must hold in_data stable while in_valid & !in_ready.
//  - Reset asserted mid-transfer: all state clears immediately. Any in-flight handshake in that cycle is lost.
// TESTING
//  1) Reset, then push 0x11 at one edge -> next cycle out_valid=1, out_data=0x11, level=1; pop -> level=0, out_valid=0.
//  2) Push 32 entries 0x00..0x1F (ADDRBITS=5), out_ready=0 -> level=32, in_ready=0, almost_full=1 from level 30; extra push not accepted.
//  3) Full FIFO, in_valid=1 and out_ready=1 for one edge -> pops 0x00, no push, level=31; next edge the push is accepted.
//  4) Continuous push+pop for 100 entries at level 1 -> pointers wrap past 31, data out in order, level constant 1.
//  5) Level 10, high_water=12; assert flush with in_valid=1 -> next cycle level=0, high_water=0, out_valid=0, write not performed.
//  6) Assert reset asynchronously between edges at level 7 -> level, high_water, out_valid drop to 0 without a clock edge.

Source files
------------

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a dual-port RAM.
// Used as the refill/writeback buffer between cache core and memory bus.

module dpram #(
    parameter int DATABITS = 8,
    parameter int ADDRBITS = 5
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDRBITS-1:0] wraddr,
    input  logic [DATABITS-1:0] d,
    input  logic [ADDRBITS-1:0] rdaddr,
    output logic [DATABITS-1:0] q
);

    logic [DATABITS-1:0] mem [0:(2**ADDRBITS)-1];

    // Synchronous write port; contents are never reset
    always_ff @(posedge clk) begin
        if (we)
            mem[wraddr] <= d;
    end

    assign q = mem[rdaddr];

endmodule

module dpram_fifo_ctrl #(
    parameter int DATABITS = 8,
    parameter int ADDRBITS = 5,
    parameter int AFULL    = (2**ADDRBITS) - 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATABITS-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATABITS-1:0] out_data,
    output logic [ADDRBITS:0]   level,
    output logic                almost_full,
    output logic [ADDRBITS:0]   high_water
);

    localparam int DEPTH = 2**ADDRBITS;
    localparam logic [ADDRBITS:0] DEPTH_L = (ADDRBITS+1)'(DEPTH);
    localparam logic [ADDRBITS:0] AFULL_L = (ADDRBITS+1)'(AFULL);

    logic [ADDRBITS-1:0] wrptr;
    logic [ADDRBITS-1:0] rdptr;
    logic [ADDRBITS:0]   level_n;
    logic                push;
    logic                pop;
    logic                we;

    // Flags come from registered level only, so no out_ready->in_ready path
    assign in_ready    = (level != DEPTH_L);
    assign out_valid   = (level != '0);
    assign almost_full = (level >= AFULL_L);

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;
    assign we   = push & ~flush;

    dpram #(
        .DATABITS (DATABITS),
        .ADDRBITS (ADDRBITS)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .wraddr (wrptr),
        .d      (in_data),
        .rdaddr (rdptr),
        .q      (out_data)
    );

    // Occupancy after this edge, ignoring flush
    always_comb begin
        level_n = level;
        if (push && !pop)
            level_n = level + 1'b1;
        else if (pop && !push)
            level_n = level - 1'b1;
    end

    // Pointer, level and high-water state; flush beats push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrptr      <= '0;
            rdptr      <= '0;
            level      <= '0;
            high_water <= '0;
        end else if (flush) begin
            wrptr      <= '0;
            rdptr      <= '0;
            level      <= '0;
            high_water <= '0;
        end else begin
            if (push)
                wrptr <= wrptr + 1'b1;
            if (pop)
                rdptr <= rdptr + 1'b1;
            level <= level_n;
            if (level_n > high_water)
                high_water <= level_n;
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl: vector table plus corner sequences.
// Inputs change on falling edges; outputs are sampled on falling edges.

module tb_dpram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [5:0] level;
    logic       almost_full;
    logic [5:0] high_water;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(
        .DATABITS (8),
        .ADDRBITS (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .almost_full (almost_full),
        .high_water  (high_water)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        int         lvl;
        logic       ov;
        logic [7:0] od;
        logic       ir;
        logic       af;
        int         hw;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic [7:0] d,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic do_flush();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        // vector table: inputs for one edge, outputs after it
        tbl[0] = '{1, 8'h11, 0, 0, 1, 1, 8'h11, 1, 0, 1};
        tbl[1] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 1};
        tbl[2] = '{1, 8'h22, 1, 0, 1, 1, 8'h22, 1, 0, 1};
        tbl[3] = '{1, 8'h33, 0, 0, 2, 1, 8'h22, 1, 0, 2};
        tbl[4] = '{1, 8'h44, 1, 0, 2, 1, 8'h33, 1, 0, 2};
        tbl[5] = '{0, 8'h00, 0, 0, 2, 1, 8'h33, 1, 0, 2};
        tbl[6] = '{0, 8'h00, 1, 0, 1, 1, 8'h44, 1, 0, 2};
        tbl[7] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 2};
        tbl[8] = '{1, 8'h99, 0, 1, 0, 0, 8'h00, 1, 0, 0};

        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #12;
        chk("rst_level", 32'(level), 0);
        chk("rst_hw", 32'(high_water), 0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_ir", 32'(in_ready), 1);
        chk("rst_af", 32'(almost_full), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            step();
            chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("v%0d_ir", i), 32'(in_ready), 32'(tbl[i].ir));
            chk($sformatf("v%0d_af", i), 32'(almost_full), 32'(tbl[i].af));
            chk($sformatf("v%0d_hw", i), 32'(high_water), 32'(tbl[i].hw));
            if (tbl[i].ov)
                chk($sformatf("v%0d_od", i), 32'(out_data), 32'(tbl[i].od));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // fill to full with 0x00..0x1F
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            step();
            chk($sformatf("fill%0d_level", i), 32'(level), 32'(i + 1));
            chk($sformatf("fill%0d_af", i), 32'(almost_full),
                32'((i + 1) >= 30));
            chk($sformatf("fill%0d_ir", i), 32'(in_ready),
                32'((i + 1) != 32));
        end
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        step();
        chk("full_level", 32'(level), 32);
        chk("full_head", 32'(out_data), 32'h00);
        chk("full_hw", 32'(high_water), 32);

        // full with push and pop together: only the pop happens
        drive(1'b1, 8'hBB, 1'b1, 1'b0);
        step();
        chk("fullpp_level", 32'(level), 31);
        chk("fullpp_head", 32'(out_data), 32'h01);
        chk("fullpp_ir", 32'(in_ready), 1);
        drive(1'b1, 8'hBB, 1'b0, 1'b0);
        step();
        chk("refill_level", 32'(level), 32);

        // drain in order: 0x01..0x1F then 0xBB
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("drain%0d_od", i), 32'(out_data),
                (i < 31) ? 32'(i + 1) : 32'hBB);
            step();
        end
        chk("drain_level", 32'(level), 0);
        chk("drain_ov", 32'(out_valid), 0);

        // streaming at level 1 across several pointer wraps
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 8'(k + 1), 1'b1, 1'b0);
            step();
            chk($sformatf("str%0d_level", k), 32'(level), 1);
            chk($sformatf("str%0d_od", k), 32'(out_data), 32'((k + 1) & 8'hFF));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        chk("str_empty", 32'(level), 0);

        // flush with a coincident push at level 10, high_water 12
        do_flush();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        step();
        chk("pre_fl_level", 32'(level), 10);
        chk("pre_fl_hw", 32'(high_water), 12);
        chk("pre_fl_od", 32'(out_data), 32'h42);
        drive(1'b1, 8'hEE, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("fl_level", 32'(level), 0);
        chk("fl_hw", 32'(high_water), 0);
        chk("fl_ov", 32'(out_valid), 0);
        chk("fl_ir", 32'(in_ready), 1);
        step();
        chk("fl_nopush", 32'(level), 0);

        // asynchronous reset between edges at level 7
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        chk("pre_rst_level", 32'(level), 7);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_level", 32'(level), 0);
        chk("arst_hw", 32'(high_water), 0);
        chk("arst_ov", 32'(out_valid), 0);
        chk("arst_ir", 32'(in_ready), 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("post_rst_level", 32'(level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
